// File: rtl/uart_apb_sequencer.sv
// APB master that programs a 16550-style UART (LCR/DLL/DLM/FCR), then moves bytes
// from two round-robin requesters into THR, polling LSR.THRE before each write.
module uart_apb_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          POLL_MAX  = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] cfg_divisor,
    input  logic [7:0]  cfg_lcr,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        out_psel,
    output logic        out_penable,
    output logic        out_pwrite,
    output logic [31:0] out_paddr,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    output logic [2:0]  out_pprot,
    input  logic        out_pready,
    input  logic        out_pslverr,
    input  logic [31:0] out_prdata,
    output logic        init_done,
    output logic        busy,
    output logic        err
);
    typedef enum logic [3:0] {
        IDLE, I_LCRD, I_DLL, I_DLM, I_LCR, I_FCR, ARB, POLL, WTHR
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_ACCESS, PH_IDLE} phase_t;

    localparam int          CW            = $clog2(POLL_MAX + 1);
    localparam logic [31:0] LSR_THRE_MASK = 32'h0000_2000; // LSR is reg 5: lane 1, bit 5

    state_t      state_q, state_d;
    phase_t      phase_q;
    logic        psel_q, penable_q, pwrite_q;
    logic [31:0] paddr_q, pwdata_q;
    logic [3:0]  pstrb_q;
    logic [15:0] div_q;
    logic [7:0]  lcr_q, byte_q;
    logic [CW-1:0] poll_cnt_q;
    logic        thre_q, last1_q, init_done_q, busy_q, err_q;

    logic        grant0, grant1, in_arb, launch, launch_write;
    logic [2:0]  launch_k;
    logic [7:0]  launch_byte;

    // last1_q=1 means req1 was served last, so req0 wins a tie.
    assign in_arb = (state_q == ARB) && init_done_q;
    assign grant0 = in_arb && req0_valid && (!req1_valid || last1_q);
    assign grant1 = in_arb && req1_valid && (!req0_valid || !last1_q);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = I_LCRD;
            I_LCRD:  state_d = I_DLL;
            I_DLL:   state_d = I_DLM;
            I_DLM:   state_d = I_LCR;
            I_LCR:   state_d = I_FCR;
            I_FCR:   state_d = ARB;
            ARB: begin
                if (grant0 || grant1) state_d = POLL;
                else if (start)       state_d = I_LCRD;
            end
            POLL: begin
                if (thre_q)                            state_d = WTHR;
                else if (poll_cnt_q == CW'(POLL_MAX))  state_d = ARB;
            end
            WTHR:    state_d = ARB;
            default: state_d = IDLE;
        endcase
    end

    // Leaving IDLE/ARB launches immediately; access states launch after their idle cycle.
    assign launch = (state_q == IDLE || state_q == ARB) ? (state_d != state_q)
                                                        : (phase_q == PH_IDLE && state_d != ARB);

    always_comb begin
        launch_k     = 3'd0;
        launch_byte  = 8'h00;
        launch_write = 1'b1;
        unique case (state_d)
            I_LCRD: begin launch_k = 3'd3; launch_byte = cfg_lcr | 8'h80; end
            I_DLL:  begin launch_k = 3'd0; launch_byte = div_q[7:0];      end
            I_DLM:  begin launch_k = 3'd1; launch_byte = div_q[15:8];     end
            I_LCR:  begin launch_k = 3'd3; launch_byte = lcr_q & 8'h7F;   end
            I_FCR:  begin launch_k = 3'd2; launch_byte = 8'h07;           end
            POLL:   begin launch_k = 3'd5; launch_write = 1'b0;           end
            WTHR:   begin launch_k = 3'd0; launch_byte = byte_q;          end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments only; reset is synchronous.
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= PH_SETUP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            div_q       <= '0;
            lcr_q       <= '0;
            byte_q      <= '0;
            poll_cnt_q  <= '0;
            thre_q      <= 1'b0;
            last1_q     <= 1'b1;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (state_q == IDLE || state_q == ARB) begin
                if (launch) begin
                    state_q <= state_d;
                    busy_q  <= 1'b1;
                    if (state_d == I_LCRD) begin
                        div_q       <= cfg_divisor;
                        lcr_q       <= cfg_lcr;
                        init_done_q <= 1'b0;
                    end else begin
                        byte_q     <= grant0 ? req0_data : req1_data;
                        last1_q    <= grant1;
                        poll_cnt_q <= '0;
                    end
                end
            end else begin
                unique case (phase_q)
                    PH_SETUP: begin
                        penable_q <= 1'b1;
                        phase_q   <= PH_ACCESS;
                    end
                    PH_ACCESS: if (out_pready) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        phase_q   <= PH_IDLE;
                        if (out_pslverr) err_q <= 1'b1;
                        if (state_q == POLL) begin
                            thre_q     <= |(out_prdata & LSR_THRE_MASK);
                            poll_cnt_q <= poll_cnt_q + 1'b1;
                        end
                    end
                    PH_IDLE: begin
                        state_q <= state_d;
                        busy_q  <= (state_d != ARB);
                        if (state_q == I_FCR) init_done_q <= 1'b1;
                        // THRE never came: the latched byte is dropped.
                        if (state_q == POLL && state_d == ARB) err_q <= 1'b1;
                    end
                    default: phase_q <= PH_IDLE;
                endcase
            end

            if (launch) begin
                psel_q    <= 1'b1;
                penable_q <= 1'b0;
                phase_q   <= PH_SETUP;
                pwrite_q  <= launch_write;
                paddr_q   <= BASE_ADDR + {29'd0, launch_k};
                pwdata_q  <= {4{launch_byte}};
                pstrb_q   <= 4'b0001 << launch_k[1:0];
            end
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign out_psel    = psel_q;
    assign out_penable = penable_q;
    assign out_pwrite  = pwrite_q;
    assign out_paddr   = paddr_q;
    assign out_pwdata  = pwdata_q;
    assign out_pstrb   = pstrb_q;
    assign out_pprot   = 3'b000;
    assign init_done   = init_done_q;
    assign busy        = busy_q;
    assign err         = err_q;
endmodule

// File: doc/uart_apb_sequencer.md
UART_APB_SEQUENCER -- requirements
Module: uart_apb_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, UART register block base address.
REQ-002 SHALL have parameter POLL_MAX, default 1023, maximum LSR reads per byte before timeout.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clock  in  1  sole clock; all state changes on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse that begins the init sequence.
REQ-007 cfg_divisor  in  16  baud divisor latch value; sampled at start.
REQ-008 cfg_lcr  in  8  line control value, bit7 ignored; sampled at start.
REQ-009 req0_valid / req1_valid  in  1  requester has a TX byte.
REQ-010 req0_data / req1_data  in  8  TX byte.
REQ-011 req0_ready / req1_ready  out  1  one-cycle pulse when the byte is accepted.
REQ-012 out_psel, out_penable, out_pwrite  out  1 each  APB master controls.
REQ-013 out_paddr  out  32; out_pwdata  out  32; out_pstrb  out  4; out_pprot  out  3 (always 3'b000).
REQ-014 out_pready, out_pslverr  in  1 each; out_prdata  in  32.
REQ-015 init_done  out  1  UART configured, TX service active.
REQ-016 busy  out  1  APB transfer or init in progress.
REQ-017 err  out  1  sticky: pslverr seen or poll timeout.

Function
REQ-018 SHALL address register k (0..7) as out_paddr = BASE_ADDR + k, out_pwdata = {4{byte}}, out_pstrb = 4'b0001 << k[1:0]; reads SHALL take byte lane k[1:0] of out_prdata.
REQ-019 Each APB access SHALL be: SETUP (psel=1, penable=0), then ACCESS (psel=1, penable=1) held until out_pready=1, then one idle cycle (psel=0); minimum 3 cycles per access.
REQ-020 paddr/pwrite/pwdata/pstrb SHALL remain stable from SETUP through the final ACCESS cycle.
REQ-021 States: IDLE, I_LCRD, I_DLL, I_DLM, I_LCR, I_FCR, ARB, POLL, WTHR.
REQ-022 IDLE: on start, latch cfg, set busy, clear init_done, go to I_LCRD.
REQ-023 Init writes in order: LCR(3) = cfg_lcr|8'h80; DLL(0) = divisor[7:0]; DLM(1) = divisor[15:8]; LCR(3) = cfg_lcr&8'h7F; FCR(2) = 8'h07; then init_done=1, go to ARB.
REQ-024 ARB: round-robin arbitration; if only one valid, grant it; if both valid, grant the requester not granted last; reset priority favours req0.
REQ-025 Grant SHALL pulse the granted reqN_ready in the ARB cycle, latch its data, and go to POLL; the non-granted requester SHALL see ready=0.
REQ-026 POLL: read LSR(5); if bit5 (THRE)=1, go to WTHR; otherwise repeat the read, incrementing the poll counter.
REQ-027 If POLL_MAX reads complete with THRE=0, SHALL set err, drop the byte, and return to ARB.
REQ-028 WTHR: write latched byte to THR(0), then return to ARB; byte-to-byte minimum is ARB + 2 accesses = 7 cycles.
REQ-029 out_pslverr=1 on a completing ACCESS SHALL set err; the sequence SHALL continue unchanged.
REQ-030 start in ARB with no grant that cycle SHALL re-run init (init_done cleared); start in any other state SHALL be ignored.
REQ-031 busy SHALL be 1 in every state except IDLE and ARB.
REQ-032 No requester SHALL be granted while init_done=0.

Reset
REQ-033 While reset is sampled high, all outputs SHALL be 0 on the next edge: psel, penable, pwrite, paddr, pwdata, pstrb, ready pulses, init_done, busy, err; state IDLE; priority favours req0.
REQ-034 Reset mid-transfer SHALL abort the transfer immediately, without completing ACCESS, and discard any latched byte.

Verification
V-1 start, divisor=16'h0102, lcr=8'h03, pready always 1 -> writes (addr+3, 83, strb 1000), (+0, 02, 0001), (+1, 01, 0010), (+3, 03, 1000), (+2, 07, 0100); init_done=1 on cycle 16 after start.
V-2 Both requesters valid, data A5/5A, LSR=8'h60 -> req0 granted first, then req1; THR writes A5 then 5A.
V-3 LSR returns 8'h00 three times, then 8'h20 -> 4 LSR reads, then 1 THR write; err stays 0.
V-4 POLL_MAX=4, LSR always 8'h00 -> 4 reads, err=1, return to ARB, no THR write.
V-5 pready delayed 3 cycles on a DLL write -> ACCESS held 4 cycles with stable address and data; sequence completes correctly.
V-6 Reset asserted during POLL ACCESS -> psel=0, init_done=0, busy=0 next cycle; requesters receive no ready pulse until after a new init.
